// File: rtl/modsub_corr_u_pkg.sv
// ============================================================================
// modsub_corr_u_pkg : stage-enable parameters and latency helper
// Rev 1.0
// ============================================================================
`default_nettype none

package modsub_corr_u_pkg;

  typedef struct packed {
    logic ff_in;
    logic ff_sub;
    logic ff_out;
  } modsub_corr_u_params_t;

  localparam modsub_corr_u_params_t MODSUB_CORR_U_DEFAULTS =
    '{ff_in: 1'b1, ff_sub: 1'b1, ff_out: 1'b1};

  // Sideband logic around the subtractor delays by this many cycles to stay aligned.
  function automatic int modsub_corr_u_lat(modsub_corr_u_params_t p);
    return int'(p.ff_in) + int'(p.ff_sub) + int'(p.ff_out);
  endfunction

endpackage

`default_nettype wire

// File: rtl/modsub_corr_u_if.sv
// ============================================================================
// modsub_corr_u_if : valid/ready operand and result bus of the subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

interface modsub_corr_u_if #(
  parameter int LOGQ = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [LOGQ-1:0] A;
  logic [LOGQ-1:0] B;
  logic            out_valid;
  logic            out_ready;
  logic [LOGQ-1:0] T;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, T
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, T
  );
endinterface

`default_nettype wire

// File: rtl/vr_pipe_stage.sv
// ============================================================================
// vr_pipe_stage : one valid bit plus W-bit data, loaded on global advance
// Rev 1.0
// ============================================================================
`default_nettype none

module vr_pipe_stage #(
  parameter int W  = 8,
  parameter bit EN = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         adv,
  input  wire logic         in_valid,
  input  wire logic [W-1:0] in_data,
  output logic              out_valid,
  output logic [W-1:0]      out_data
);

  if (EN) begin : g_reg
    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_valid <= 1'b0;
      end else if (adv) begin
        r_valid <= in_valid;
      end
    end

    // Data is left unreset; it is qualified by r_valid everywhere downstream.
    always_ff @(posedge clk) begin
      if (adv) begin
        r_data <= in_data;
      end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
  end else begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, adv};
    assign out_valid   = in_valid;
    assign out_data    = in_data;
  end

endmodule

`default_nettype wire

// File: rtl/modsub_corr_u.sv
// ============================================================================
// modsub_corr_u : pipelined T = (A - B) mod q with conditional add-back of q
// Rev 1.0
// ============================================================================
`default_nettype none

module modsub_corr_u
  import modsub_corr_u_pkg::*;
#(
  parameter int LOGQ   = 64,
  parameter int LOGQH  = 17,
  parameter bit FF_IN  = 1'b1,
  parameter bit FF_SUB = 1'b1,
  parameter bit FF_OUT = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [LOGQH-1:0] qH,
  modsub_corr_u_if.slave        bus
);

  localparam modsub_corr_u_params_t P = '{ff_in: FF_IN, ff_sub: FF_SUB, ff_out: FF_OUT};
  localparam int LAT = modsub_corr_u_lat(P);
  localparam int R   = LOGQ - LOGQH;

  logic [LOGQ-1:0]   w_q;
  logic              w_adv;
  logic              w_s1_valid;
  logic              w_s2_valid;
  logic [2*LOGQ-1:0] w_s1_data;
  logic [LOGQ-1:0]   w_a;
  logic [LOGQ-1:0]   w_b;
  logic [LOGQ:0]     w_d;
  logic [LOGQ:0]     w_s2_data;
  logic [LOGQ-1:0]   w_t;

  // Montgomery-friendly modulus: low R bits are 0...01.
  if (R == 0) begin : g_q_full
    assign w_q = qH;
  end else if (R == 1) begin : g_q_r1
    assign w_q = {qH, 1'b1};
  end else begin : g_q_rn
    assign w_q = {qH, {(R-1){1'b0}}, 1'b1};
  end

  if (LAT == 0) begin : g_comb
    assign w_adv        = bus.out_ready;
    assign bus.in_ready = bus.out_ready;
  end else begin : g_elastic
    assign w_adv        = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = w_adv;
  end

  vr_pipe_stage #(.W(2*LOGQ), .EN(FF_IN)) u_st_in (
    .clk       (clk),
    .rst       (rst),
    .adv       (w_adv),
    .in_valid  (bus.in_valid),
    .in_data   ({bus.A, bus.B}),
    .out_valid (w_s1_valid),
    .out_data  (w_s1_data)
  );

  assign {w_a, w_b} = w_s1_data;
  assign w_d        = {1'b0, w_a} - {1'b0, w_b};

  vr_pipe_stage #(.W(LOGQ+1), .EN(FF_SUB)) u_st_sub (
    .clk       (clk),
    .rst       (rst),
    .adv       (w_adv),
    .in_valid  (w_s1_valid),
    .in_data   (w_d),
    .out_valid (w_s2_valid),
    .out_data  (w_s2_data)
  );

  // Borrow out of the extended difference means A < B: fold back into [0, q).
  assign w_t = w_s2_data[LOGQ-1:0] + (w_s2_data[LOGQ] ? w_q : '0);

  vr_pipe_stage #(.W(LOGQ), .EN(FF_OUT)) u_st_out (
    .clk       (clk),
    .rst       (rst),
    .adv       (w_adv),
    .in_valid  (w_s2_valid),
    .in_data   (w_t),
    .out_valid (bus.out_valid),
    .out_data  (bus.T)
  );

endmodule

`default_nettype wire

// File: tb/tb_modsub_corr_u.sv
// ============================================================================
// tb_modsub_corr_u : scoreboard bench for modsub_corr_u, q = 161, LAT = 3 and 0
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_modsub_corr_u;

  localparam int LOGQ  = 8;
  localparam int LOGQH = 3;
  localparam int Q     = 161;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] qH  = 3'b101;

  always #5 clk = ~clk;

  modsub_corr_u_if #(.LOGQ(LOGQ)) bus  ();
  modsub_corr_u_if #(.LOGQ(LOGQ)) bus0 ();

  modsub_corr_u #(.LOGQ(LOGQ), .LOGQH(LOGQH)) dut (
    .clk (clk),
    .rst (rst),
    .qH  (qH),
    .bus (bus)
  );

  modsub_corr_u #(.LOGQ(LOGQ), .LOGQH(LOGQH),
                  .FF_IN(1'b0), .FF_SUB(1'b0), .FF_OUT(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .qH  (qH),
    .bus (bus0)
  );

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] sb[$];

  function automatic logic [7:0] model(logic [7:0] a, logic [7:0] b);
    int r;
    r = (int'(a) - int'(b) + Q) % Q;
    return r[7:0];
  endfunction

  // Pushes on every accepted input, pops and compares on every emitted result.
  task automatic monitor();
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        sb.delete();
      end else begin
        if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.A, bus.B));
        if (bus.out_valid && bus.out_ready) begin
          compared++;
          if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL sb_spurious: T=%0d emitted, expected no output", bus.T);
          end else begin
            exp = sb.pop_front();
            if (bus.T !== exp) begin
              mismatched++;
              $display("FAIL sb_order: T=%0d, expected %0d", bus.T, exp);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.A = 8'd10;
    bus.B = 8'd5;
    repeat (4) @(negedge clk);
    #1;
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
    end
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release_idle: out_valid=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic single(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                        input string name);
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.out_ready = 1'b1;
    #1;
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_in_ready: got %b, expected 1", name, bus.in_ready);
    end
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
      #1;
    end while (!bus.out_valid && lat < 10);
    compared++;
    if (lat !== 3) begin
      mismatched++;
      $display("FAIL %s_latency: got %0d cycles, expected 3", name, lat);
    end
    compared++;
    if (bus.T !== exp) begin
      mismatched++;
      $display("FAIL %s_value: T=%0d, expected %0d", name, bus.T, exp);
    end
  endtask

  task automatic test_directed();
    single(8'd10, 8'd5,   8'd5,   "d_10_5");
    single(8'd5,  8'd10,  8'd156, "d_5_10");
    single(8'd0,  8'd160, 8'd1,   "d_0_160");
    single(8'd77, 8'd77,  8'd0,   "d_77_77");
    single(8'd160, 8'd0,  8'd160, "d_160_0");
  endtask

  task automatic test_back_to_back();
    int outs;
    int first;
    int last;
    outs  = 0;
    first = -1;
    last  = -1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && outs < 20; c++) begin
      @(negedge clk);
      if (c < 20) begin
        bus.in_valid = 1'b1;
        bus.A = 8'($urandom_range(0, Q-1));
        bus.B = 8'($urandom_range(0, Q-1));
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid) begin
        if (outs == 0) first = c;
        last = c;
        outs++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3;
    compared++;
    if (outs !== 20) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d results, expected 20", outs);
    end
    compared++;
    if (last - first !== 19) begin
      mismatched++;
      $display("FAIL b2b_consecutive: span %0d cycles, expected 19", last - first);
    end
    compared++;
    if (sb.size() !== 0) begin
      mismatched++;
      $display("FAIL b2b_drain: %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_stall();
    int         acc;
    int         outs;
    int         sent;
    logic [7:0] held_t;
    logic [7:0] ca;
    logic [7:0] cb;
    acc = 0;
    ca  = 8'($urandom_range(0, Q-1));
    cb  = 8'($urandom_range(0, Q-1));
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A = ca;
      bus.B = cb;
      #1;
      if (!bus.in_ready) break;
      acc++;
      ca = 8'($urandom_range(0, Q-1));
      cb = 8'($urandom_range(0, Q-1));
    end
    compared++;
    if (acc !== 3) begin
      mismatched++;
      $display("FAIL stall_fill: accepted %0d, expected 3", acc);
    end
    held_t = bus.T;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      compared++;
      if (bus.in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_in_ready: got %b, expected 0", bus.in_ready);
      end
      compared++;
      if (bus.out_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL stall_out_valid: got %b, expected 1", bus.out_valid);
      end
      compared++;
      if (bus.T !== held_t) begin
        mismatched++;
        $display("FAIL stall_hold_T: got %0d, expected %0d", bus.T, held_t);
      end
    end
    // Release and keep streaming, then drain.
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (sent < 4);
      bus.A = ca;
      bus.B = cb;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        sent++;
        ca = 8'($urandom_range(0, Q-1));
        cb = 8'($urandom_range(0, Q-1));
      end
      if (sent >= 4 && sb.size() <= 1 && !bus.out_valid) break;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3;
    compared++;
    if (sb.size() !== 0) begin
      mismatched++;
      $display("FAIL stall_drain: %0d pending, expected 0", sb.size());
    end
    // Consumer alternating ready every cycle.
    sent = 0;
    outs = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      bus.out_ready = c[0];
      bus.in_valid  = (sent < 10);
      bus.A = ca;
      bus.B = cb;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        sent++;
        ca = 8'($urandom_range(0, Q-1));
        cb = 8'($urandom_range(0, Q-1));
      end
      if (bus.out_valid && bus.out_ready) outs++;
      if (outs == 10) break;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    compared++;
    if (outs !== 10) begin
      mismatched++;
      $display("FAIL toggle_count: got %0d results, expected 10", outs);
    end
    compared++;
    if (sb.size() !== 0) begin
      mismatched++;
      $display("FAIL toggle_drain: %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A = 8'(20 + i);
      bus.B = 8'(3 * i);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    compared++;
    if (bus.out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_inflight: out_valid=%b, expected 1", bus.out_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_async: out_valid=%b, expected 0", bus.out_valid);
    end
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_in_ready: got %b, expected 1", bus.in_ready);
    end
    @(negedge clk);
    #3;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      compared++;
      if (bus.out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL rstmid_stale: out_valid=%b after release, expected 0", bus.out_valid);
      end
    end
    single(8'd10, 8'd5, 8'd5, "rstmid_new");
  endtask

  task automatic test_comb();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] ve [3];
    va = '{8'd5, 8'd10, 8'd0};
    vb = '{8'd10, 8'd5, 8'd160};
    ve = '{8'd156, 8'd5, 8'd1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus0.in_valid  = 1'b1;
      bus0.out_ready = 1'b1;
      bus0.A = va[i];
      bus0.B = vb[i];
      #1;
      compared++;
      if (bus0.T !== ve[i] || bus0.out_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL comb_value: T=%0d valid=%b, expected T=%0d valid=1",
                 bus0.T, bus0.out_valid, ve[i]);
      end
      compared++;
      if (bus0.in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL comb_ready_hi: in_ready=%b, expected 1", bus0.in_ready);
      end
      bus0.out_ready = 1'b0;
      #1;
      compared++;
      if (bus0.in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL comb_ready_lo: in_ready=%b, expected 0", bus0.in_ready);
      end
      bus0.in_valid = 1'b0;
      #1;
      compared++;
      if (bus0.out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL comb_valid_lo: out_valid=%b, expected 0", bus0.out_valid);
      end
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    bus.out_ready  = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.A         = '0;
    bus0.B         = '0;
    bus0.out_ready = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_comb();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/modsub_corr_u.md
Name: modsub_corr_u

Overview:
- Pipelined modular subtractor with a conditional-add correction: T = (A − B) mod q, for A, B in [0, q).
- Counterpart to the conditional-subtract correction on the Montgomery output path. It adds q back when the raw difference goes negative, rather than subtracting q when the value is too large.
- Uses the same Montgomery-friendly modulus form: q = {qH, zeros, 1'b1}.
- Sits in the butterfly/NTT datapath after the multiplier. Adds valid/ready flow control so it can be stalled by downstream consumers.

Parameters:
- LOGQ, 64: modulus/operand width in bits.
- LOGQH, 17: width of the high modulus part qH. R = LOGQ − LOGQH low bits are implied, 0…01.
- FF_IN, 1: register A/B at input (1 = stage present).
- FF_SUB, 1: register the raw difference D and the sign.
- FF_OUT, 1: register the corrected result T.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- qH  in  LOGQH  high part of modulus; quasi-static, changed only while pipeline is empty.
- in_valid  in  1  A/B valid.
- in_ready  out  1  block accepts A/B this cycle.
- A  in  LOGQ  minuend, A < q.
- B  in  LOGQ  subtrahend, B < q.
- out_valid  out  1  T valid.
- out_ready  in  1  consumer accepts T.
- T  out  LOGQ  (A − B) mod q.

Behaviour:
- Modulus construction:
  - q = {qH, {(R−1){0}}, 1} when R ≠ 0.
  - q = qH when R = 0; LOGQH must then equal LOGQ.
- Arithmetic:
  - D = {1'b0,A} − {1'b0,B}, LOGQ+1 bits.
  - If D[LOGQ] = 1: T = D[LOGQ−1:0] + q, truncated to LOGQ bits. Otherwise T = D[LOGQ−1:0].
  - Result is always in [0, q).
  - Inputs ≥ q are out of contract; output is unspecified but must not hang.
- Latency: LAT = FF_IN + FF_SUB + FF_OUT cycles from accepted input to out_valid, with no stalls.
- Stage contents: each enabled stage holds a valid bit plus data.
  - FF_IN stage: A, B.
  - FF_SUB stage: D.
  - FF_OUT stage: T.
  - Disabled stages are wires.
- Flow control uses a global-enable elastic pipeline:
  - adv = ~out_valid | out_ready.
  - in_ready = adv.
  - All enabled stages load on adv. A stage's valid bit loads the upstream valid, with in_valid at the head.
  - Data registers load only when adv is high. On stall they hold.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Bubbles: when the pipeline is not full and out_valid = 0, adv = 1, so bubbles collapse and the pipeline never deadlocks.
- Ordering: results emerge strictly in acceptance order. There is no drop and no duplication under any out_ready pattern.
- Stall while valid: out_valid and T hold stable until out_ready is sampled high.
- LAT = 0: the block is purely combinational. out_valid = in_valid, in_ready = out_ready, T = f(A, B).
- Reset (rst low, any time, including mid-operation):
  - All valid bits clear immediately, so out_valid = 0.
  - in_ready = 1 while in reset, because out_valid = 0.
  - Data registers are not reset; T is don't-care while out_valid = 0.
  - After rst rises, no stale result is ever emitted.
- Simultaneous output pop and input push in a full pipeline: both complete in the same cycle, sustaining 1 result/cycle.

Decomposition:
- Shared package (alongside the existing correction-unit params): typedef modsub_corr_u_params_t {FF_IN, FF_SUB, FF_OUT}.
- Function modsub_corr_u_lat(params) returns the sum of the enable bits; instantiators use it to align sideband delays.
- One sub-module is natural: vr_pipe_stage.
  - Parameters: W, EN.
  - Contains one valid bit plus a W-bit data register, loaded on adv.
  - Instantiated three times.

Test Plan (LOGQ=8, LOGQH=3, qH=3'b101 → q=0xA1=161; default FFs, LAT=3):
- A=10, B=5, out_ready=1 → out_valid exactly 3 cycles after accept, T=5.
- A=5, B=10 → T=156. A=0, B=160 → T=1. A=77, B=77 → T=0. A=160, B=0 → T=160.
- 20 back-to-back random in-range pairs, out_ready=1 → 20 results in consecutive cycles, matching the model, in order.
- Full pipeline, out_ready=0 for 5 cycles:
  - in_ready=0 throughout; T and out_valid held stable.
  - On release, all results drain in order with none lost.
  - Repeat with out_ready toggling every cycle: results still match and stay in order.
- Assert rst low for 1 cycle with 3 items in flight → out_valid=0 immediately (asynchronous); nothing is emitted after release until a new input. A new A=10, B=5 then yields T=5 after 3 cycles.
- FF_IN=FF_SUB=FF_OUT=0: A=5, B=10 → T=156 in the same cycle, in_ready follows out_ready.
